uart_rx: RTL



---
 rtl/uart_rx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with midpoint sampling and framing-error detection
module uart_rx #(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  // Terminal counts: a full bit period and half a bit period, minus one.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]  state;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;
  logic        rx_meta;
  logic        rx_sync;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive state machine: start qualification, data shift, stop check, break hold-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_count  <= 16'd0;
      bit_index  <= 3'd0;
      shift_reg  <= 8'h00;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= 16'd0;
          bit_index <= 3'd0;
          if (!rx_sync) begin
            state <= START;
          end
        end
        START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= 16'd0;
            // A line that is high again at mid start bit was only a glitch.
            state     <= rx_sync ? IDLE : DATA;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        DATA: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= 16'd0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            if (bit_index == 3'd7) begin
              bit_index <= 3'd0;
              state     <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        STOP: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= 16'd0;
            // Leaving at the stop-bit midpoint leaves room to catch an immediate next start.
            if (rx_sync) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        BREAK: begin
          clk_count <= 16'd0;
          // Hold here while the line stays low so a break cannot look like a new start.
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          clk_count <= 16'd0;
          bit_index <= 3'd0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
